// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with one-entry skid and flush.
// Define PIPE_STAGE_STALL_CNT_EN to add the saturating stall_cnt output.
//
// Ports:
//   clk, clr (async high)      clock and reset
//   flush                      sync squash of held entries
//   in_valid/in_ready/in_data  upstream handshake (in_ready is a flop)
//   out_valid/out_ready/out_data downstream handshake (out_data = main reg)
//   stall_cnt [15:0]           only with PIPE_STAGE_STALL_CNT_EN
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // Encoding is {main_v, skid_v} so flags fall out of the state bits.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b10,
    SKID  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             issue;

  assign in_ready  = ~state_q[0];
  assign out_valid = state_q[1];
  assign out_data  = main_q;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (accept && issue) begin
          main_d = in_data;
        end else if (issue) begin
          state_d = EMPTY;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID;
        end
      end
      SKID: begin
        if (issue) begin
          main_d  = skid_q;
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops all held entries but leaves the payload regs alone.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors plus a short scoreboard run
// for pipe_stage_reg.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk;
  logic        clr;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(
    .WIDTH    (32),
    .RESET_VAL(RV)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] seq;
  logic        exp_ir, exp_ov, acc, iss;

  initial begin
    clr = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset state, before any clock edge
    #2 clr = 1'b1;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_ir", in_ready, 1);
    chk("rst_od", out_data, RV);
    tick(); tick();
    clr = 1'b0;

    // back-to-back stream, one cycle latency, no bubbles
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = i;
      tick();
      chk("strm_ov", out_valid, 1);
      chk("strm_od", out_data, i);
      chk("strm_ir", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("strm_drain", out_valid, 0);

    // skid fill and drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    chk("sk_fullA", out_data, 32'hA);
    chk("sk_ir1", in_ready, 1);
    in_data = 32'hB;
    tick();
    chk("sk_ir0", in_ready, 0);
    chk("sk_odA", out_data, 32'hA);
    in_valid = 1'b0;
    tick();
    chk("sk_holdA", out_data, 32'hA);
    chk("sk_holdv", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("sk_odB", out_data, 32'hB);
    chk("sk_ir_back", in_ready, 1);
    tick();
    chk("sk_empty", out_valid, 0);

    // flush from SKID with an offered input
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    flush = 1'b1; in_data = 32'hC;
    tick();
    chk("fl_ov", out_valid, 0);
    chk("fl_ir", in_ready, 1);
    chk("fl_keep", out_data, 32'hA);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_noC", out_valid, 0);

    // flush drops an accept in the same cycle
    in_valid = 1'b1; in_data = 32'hD; flush = 1'b1;
    tick();
    chk("fl_drop", out_valid, 0);
    chk("fl_dropd", out_data, 32'hA);
    flush = 1'b0; in_valid = 1'b0;

    // clr mid-run, effective without a clock edge
    in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    #2 clr = 1'b1;
    #1;
    chk("clr_ov", out_valid, 0);
    chk("clr_ir", in_ready, 1);
    chk("clr_od", out_data, RV);
    tick();
    chk("clr_hold", out_data, RV);
    clr = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("clr_after", out_valid, 0);

    // random traffic against a queue model
    seq = 32'h100;
    in_valid = 1'b0; in_data = seq;
    for (int c = 0; c < 2000; c++) begin
      exp_ir = (q.size() < 2);
      exp_ov = (q.size() > 0);
      chk("rnd_ir", in_ready, exp_ir);
      chk("rnd_ov", out_valid, exp_ov);
      if (exp_ov) chk("rnd_od", out_data, q[0]);
      acc = in_valid & exp_ir;
      iss = exp_ov & out_ready;
      tick();
      if (iss) void'(q.pop_front());
      if (acc) begin
        q.push_back(in_data);
        seq = seq + 1;
      end
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = seq;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    clr = 1'b1;
    #1;
    clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stall_5", stall_cnt, 5);
    repeat (70000) tick();
    chk("stall_sat", stall_cnt, 16'hFFFF);
    clr = 1'b1;
    #1;
    chk("stall_clr", stall_cnt, 0);
    clr = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
